// File: rtl/task_pkg.sv
// Shared types and widths for the task-RAM port arbiter and its helpers.
package task_pkg;

    localparam int AW = 5;
    localparam int DW = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant: round-robin when idle, exclusive to the owner while a lock is held.
module rr_arb2
    import task_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  state_t     i_state,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_state)
            IDLE: begin
                if (&i_req) begin
                    o_gnt = i_ptr ? 2'b10 : 2'b01;
                end else begin
                    o_gnt = i_req;
                end
            end
            OWN0:    o_gnt = {1'b0, i_req[0]};
            OWN1:    o_gnt = {i_req[1], 1'b0};
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port task RAM between two requesters, driving the RAM from registers
// and tagging read data with a per-requester valid strobe aligned to the RAM latency.
module ram_port_arbiter
    import task_pkg::*;
#(
    parameter int AW     = task_pkg::AW,
    parameter int DW     = task_pkg::DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,

    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    state_t               r_state;
    logic                 r_ptr;
    logic [AW-1:0]        r_ramAddr;
    logic [DW-1:0]        r_ramDin;
    logic                 r_ramWe;
    rd_entry_t [RD_LAT:0] r_rdPipe;

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_accept;
    logic          w_sel;
    logic          w_selWe;
    logic          w_selLock;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selData;
    logic          w_pipeBusy;

    assign w_req = {req1, req0};

    rr_arb2 u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_state (r_state),
        .o_gnt   (w_gnt)
    );

    assign gnt0      = w_gnt[0];
    assign gnt1      = w_gnt[1];
    assign w_accept  = |(w_req & w_gnt);
    assign w_sel     = w_gnt[1];
    assign w_selWe   = w_sel ? we1    : we0;
    assign w_selLock = w_sel ? lock1  : lock0;
    assign w_selAddr = w_sel ? addr1  : addr0;
    assign w_selData = w_sel ? wdata1 : wdata0;

    // An owner that drops its request abandons the lock; the other side gets priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (&w_req) begin
                            r_ptr <= ~w_sel;
                        end
                        if (w_selLock) begin
                            r_state <= w_sel ? OWN1 : OWN0;
                        end
                    end
                end
                OWN0: begin
                    if (!req0 || (w_accept && !lock0)) begin
                        r_state <= IDLE;
                        r_ptr   <= 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1 || (w_accept && !lock1)) begin
                        r_state <= IDLE;
                        r_ptr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramAddr <= '0;
            r_ramDin  <= '0;
            r_ramWe   <= 1'b0;
        end else begin
            r_ramWe <= w_accept && w_selWe;
            if (w_accept) begin
                r_ramAddr <= w_selAddr;
                r_ramDin  <= w_selData;
            end
        end
    end

    // Entry i is valid in the (i+1)th cycle after the accept, so the last stage meets douta.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPipe <= '0;
        end else begin
            r_rdPipe[0].valid <= w_accept && !w_selWe;
            r_rdPipe[0].owner <= w_sel;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_rdPipe[i] <= r_rdPipe[i-1];
            end
        end
    end

    always_comb begin
        w_pipeBusy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            w_pipeBusy = w_pipeBusy | r_rdPipe[i].valid;
        end
    end

    assign rvalid0  = r_rdPipe[RD_LAT].valid && !r_rdPipe[RD_LAT].owner;
    assign rvalid1  = r_rdPipe[RD_LAT].valid &&  r_rdPipe[RD_LAT].owner;
    assign rdata    = ram_dout;
    assign ram_addr = r_ramAddr;
    assign ram_din  = r_ramDin;
    assign ram_we   = r_ramWe;
    assign busy     = (r_state != IDLE) || w_pipeBusy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=2) share stimulus, each backed by a write-first RAM model.
module tb_ram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [4:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;

    logic       gnt0A, gnt1A, rvalid0A, rvalid1A, ramWeA, busyA;
    logic [3:0] rdataA, ramDinA, doutA;
    logic [4:0] ramAddrA;
    logic       gnt0B, gnt1B, rvalid0B, rvalid1B, ramWeB, busyB;
    logic [3:0] rdataB, ramDinB, doutB, stageB;
    logic [4:0] ramAddrB;

    logic [3:0] memA [32];
    logic [3:0] memB [32];

    int checks   = 0;
    int failures = 0;

    ram_port_arbiter #(.AW(5), .DW(4), .RD_LAT(1)) u_dutA (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0A), .rvalid0(rvalid0A),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1A), .rvalid1(rvalid1A),
        .rdata(rdataA), .ram_addr(ramAddrA), .ram_din(ramDinA), .ram_we(ramWeA),
        .ram_dout(doutA), .busy(busyA)
    );

    ram_port_arbiter #(.AW(5), .DW(4), .RD_LAT(2)) u_dutB (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0B), .rvalid0(rvalid0B),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1B), .rvalid1(rvalid1B),
        .rdata(rdataB), .ram_addr(ramAddrB), .ram_din(ramDinB), .ram_we(ramWeB),
        .ram_dout(doutB), .busy(busyB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-first RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ramWeA) memA[ramAddrA] <= ramDinA;
        doutA <= ramWeA ? ramDinA : memA[ramAddrA];
    end

    // Same RAM with an extra output register.
    always @(posedge clk) begin
        if (ramWeB) memB[ramAddrB] <= ramDinB;
        stageB <= ramWeB ? ramDinB : memB[ramAddrB];
        doutB  <= stageB;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [4:0] a0,
                                 input logic [3:0] d0, input logic l0,
                                 input logic r1, input logic w1, input logic [4:0] a1,
                                 input logic [3:0] d1, input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        tick();
        tick();
        checkOutput("reset ram_we", ramWeA, 1'b0);
        checkOutput("reset ram_addr", ramAddrA, 5'h00);
        checkOutput("reset ram_din", ramDinA, 4'h0);
        checkOutput("reset busy", busyA, 1'b0);
        checkOutput("reset rvalid", {rvalid1A, rvalid0A}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single read with RD_LAT=1, after writing 4'hA to 5'h01.
        applyStimulus(1, 1, 5'h01, 4'hA, 0, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t1 preload gnt0", gnt0A, 1'b1);
        tick();
        applyStimulus(1, 0, 5'h01, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t1 c0 gnt", {gnt1A, gnt0A}, 2'b01);
        tick();
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t1 c1 ram_addr", ramAddrA, 5'h01);
        checkOutput("t1 c1 ram_we", ramWeA, 1'b0);
        checkOutput("t1 c1 rvalid0", rvalid0A, 1'b0);
        checkOutput("t1 c1 busy", busyA, 1'b1);
        tick();
        checkOutput("t1 c2 rvalid0", rvalid0A, 1'b1);
        checkOutput("t1 c2 rdata", rdataA, 4'hA);
        checkOutput("t1 c2 rvalid1", rvalid1A, 1'b0);
        tick();
        checkOutput("t1 c3 rvalid0", rvalid0A, 1'b0);
        checkOutput("t1 c3 busy", busyA, 1'b0);
        tick();

        // Contention: both write continuously, grants alternate starting with requester 0.
        applyStimulus(1, 1, 5'h02, 4'h3, 0, 1, 1, 5'h03, 4'hC, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2 gntA", {gnt1A, gnt0A}, (i % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("t2 gntB", {gnt1B, gnt0B}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            checkOutput("t2 ram_we", ramWeA, 1'b1);
            checkOutput("t2 ram_addr", ramAddrA, (i % 2 == 0) ? 5'h02 : 5'h03);
        end
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        tick();
        checkOutput("t2 idle ram_we", ramWeA, 1'b0);
        tick();

        // Lock burst: requester 0 holds the port for four accepts while requester 1 waits.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 5'h04, 4'(i), (i < 3), 1, 1, 5'h05, 4'h9, 0);
            checkOutput("t3 burst gnt", {gnt1A, gnt0A}, 2'b01);
            tick();
            checkOutput("t3 busy", busyA, (i < 3));
        end
        applyStimulus(1, 1, 5'h04, 4'h0, 0, 1, 1, 5'h05, 4'h9, 0);
        checkOutput("t3 after gnt", {gnt1A, gnt0A}, 2'b10);
        tick();
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        tick();
        tick();

        // Read-after-write on requester 1 returns the freshly written value.
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 1, 1, 5'h1F, 4'h7, 0);
        checkOutput("t4 write gnt1", gnt1A, 1'b1);
        tick();
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 1, 0, 5'h1F, 4'h0, 0);
        checkOutput("t4 read gnt1", gnt1A, 1'b1);
        tick();
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        tick();
        checkOutput("t4 rvalid", {rvalid1A, rvalid0A}, 2'b10);
        checkOutput("t4 rdata", rdataA, 4'h7);
        tick();
        tick();
        tick();

        // Interleaved reads on the RD_LAT=2 instance: 0->5'h02, 1->5'h03, 0, 1.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                if (i % 2 == 0) applyStimulus(1, 0, 5'h02, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
                else            applyStimulus(0, 0, 5'h00, 4'h0, 0, 1, 0, 5'h03, 4'h0, 0);
                checkOutput("t5 gntB", {gnt1B, gnt0B}, (i % 2 == 0) ? 2'b01 : 2'b10);
            end else begin
                applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
            end
            checkOutput("t5 rvalid0B", rvalid0B, (i == 3 || i == 5));
            checkOutput("t5 rvalid1B", rvalid1B, (i == 4 || i == 6));
            checkOutput("t5 not both", rvalid0B & rvalid1B, 1'b0);
            if (i >= 3) begin
                checkOutput("t5 rdataB", rdataB, (i % 2 == 1) ? 4'h3 : 4'hC);
            end
            tick();
        end
        tick();

        // Reset while a read is in flight and a locked write is on the RAM port.
        applyStimulus(1, 0, 5'h01, 4'h0, 1, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t6 read gnt0", gnt0A, 1'b1);
        tick();
        applyStimulus(1, 1, 5'h06, 4'h5, 1, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t6 write gnt0", gnt0A, 1'b1);
        tick();
        checkOutput("t6 pre ram_we", ramWeA, 1'b1);
        checkOutput("t6 pre rvalid0", rvalid0A, 1'b1);
        checkOutput("t6 pre busy", busyA, 1'b1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        checkOutput("t6 rst ram_we", {ramWeB, ramWeA}, 2'b00);
        checkOutput("t6 rst busy", {busyB, busyA}, 2'b00);
        checkOutput("t6 rst rvalid", {rvalid1B, rvalid0B, rvalid1A, rvalid0A}, 4'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t6 post rvalid", {rvalid1B, rvalid0B, rvalid1A, rvalid0A}, 4'h0);
            checkOutput("t6 post ram_we", {ramWeB, ramWeA}, 2'b00);
            checkOutput("t6 post busy", {busyB, busyA}, 2'b00);
            tick();
        end
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 1, 0, 5'h01, 4'h0, 0);
        checkOutput("t6 lock dropped gnt1", {gnt1A, gnt0A}, 2'b10);
        tick();
        applyStimulus(0, 0, 5'h00, 4'h0, 0, 0, 0, 5'h00, 4'h0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 32x4 task RAM (addra[4:0], dina[3:0], douta[3:0], wea, clka) between two requesters, e.g. a button-driven writer and a display/scan reader.
- Arbitration is round-robin, with an optional lock so one requester can keep the port for a burst.
- The block drives the RAM port from registers and returns read data with a per-requester valid strobe aligned to the RAM read latency.
- It sits between the requester logic and the RAM instance at the top of each task design.

Parameters:
- AW, 5, RAM address width.
- DW, 4, RAM data width.
- RD_LAT, 1, cycles from the RAM sampling an address to douta being valid (1 = no BRAM output register; legal range 1..3).

Ports:
- clk  in  1  system clock; also drives the RAM clka.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- lock0  in  1  requester 0: keep ownership after this grant.
- gnt0  out  1  requester 0 request accepted this cycle.
- rvalid0  out  1  rdata carries requester 0 read result.
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1: same as above for requester 1.
- rdata  out  DW  read data, shared by both requesters (equals ram_dout).
- ram_addr  out  AW  to RAM addra.
- ram_din  out  DW  to RAM dina.
- ram_we  out  1  to RAM wea.
- ram_dout  in  DW  from RAM douta.
- busy  out  1  a lock is held or a read is outstanding.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assertion, active low.
- Reset values: ram_addr=0, ram_din=0, ram_we=0. rvalid pipeline cleared. State=IDLE. Round-robin pointer favours requester 0. busy=0.
- Handshake is valid/ready style:
  - gnt_i is combinational from req_i, the state and the pointer.
  - A transaction is accepted at the rising edge where req_i && gnt_i.
  - Requesters hold we/addr/wdata/lock stable while req_i=1 and gnt_i=0.
  - Back-to-back accepts from the same requester are legal.
- At most one grant per cycle; gnt0 && gnt1 is never true.
- State machine has three states: IDLE, OWN0, OWN1.
  - IDLE, one request: that requester is granted.
  - IDLE, both requesting: the pointer's requester is granted. The pointer then moves to the other requester.
  - Accepted with lock_i=1: next state is OWN_i.
  - OWN_i: only requester i can be granted. Requester j's req is ignored (gnt_j=0).
  - OWN_i to IDLE: on an accept with lock_i=0, or when req_i=0 in any cycle (abandoned lock). The pointer is then set to j.
- Accept at edge E0 registers the RAM port at that edge: ram_addr=addr_i, ram_din=wdata_i, ram_we=we_i. The RAM samples them at E1.
- Cycle with no accept: ram_we=0. ram_addr and ram_din hold their last values.
- Write latency: the RAM contents are updated at E1. No response strobe is generated for writes.
- Read latency: rvalid_i is high for exactly one cycle, RD_LAT+1 cycles after the accept edge. With RD_LAT=1 this is the cycle after E1.
  - Implemented as a shift register of {valid, owner} with depth RD_LAT+1.
  - rdata = ram_dout, combinational passthrough.
- Read-after-write to the same address in consecutive accepts returns the new data. The RAM is write-first; this block does no forwarding.
- Reads from alternating owners in consecutive cycles each get their own correct rvalid cycle. No read is ever dropped or reordered.
- busy = (state != IDLE) || any valid bit set in the read pipeline.
- Reset mid-operation clears outstanding reads (no rvalid after reset), forces ram_we=0 immediately, and drops any lock.

Decomposition:
- Shared package task_pkg holds:
  - constants AW=5, DW=4;
  - state enum {IDLE, OWN0, OWN1};
  - typedef for a read-pipeline entry {logic valid; logic owner;}.
- One sub-module, rr_arb2: combinational two-way grant from req[1:0], pointer and state.
- The pointer/state register and the RAM port registers stay in ram_port_arbiter.

Test Plan:
- Single read, RD_LAT=1: after reset, preload addr 5'h01=4'hA; req0=1, we0=0, addr0=5'h01. Required: gnt0 in cycle 0; ram_addr=5'h01 in cycle 1; rvalid0=1 and rdata=4'hA in cycle 2 only; rvalid1 stays 0.
- Contention: req0 and req1 both held high for 4 cycles, all writes, lock=0. Required: grants alternate 0,1,0,1 starting with 0 after reset; ram_we=1 for 4 consecutive cycles.
- Lock burst: req0 with lock0=1 for 3 accepts then lock0=0 for 1, while req1 held high. Required: gnt1=0 for all 4 accepts; gnt1=1 in the next cycle; busy=1 during the burst.
- Read-after-write: requester 1 writes 4'h7 to 5'h1F, then reads 5'h1F in the next cycle. Required: rvalid1 with rdata=4'h7.
- Interleaved reads: alternating reads 0→5'h02 (4'h3), 1→5'h03 (4'hC), RD_LAT=2. Required: rvalid0 and rvalid1 in alternate cycles with the correct data; never both high in the same cycle.
- Reset mid-read: assert rst_n=0 one cycle after a read accept. Required: ram_we=0, busy=0 and no rvalid for 5 cycles after reset is released.
